// File: rtl/vegeta_sparse_pe_pkg.sv
// rtl/vegeta_sparse_pe_pkg.sv - shared types for the sparse PE: loader states, weight entry, width helper
package vegeta_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } ld_state_e;

    // Entry fields are sized for the widest supported configuration; unused upper bits are tied to zero.
    localparam int META_MAX_W = 8;
    localparam int MUL_MAX_W  = 32;

    typedef struct packed {
        logic [META_MAX_W-1:0] meta;
        logic [MUL_MAX_W-1:0]  value;
    } w_entry_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vegeta_sparse_pe_if.sv
// rtl/vegeta_sparse_pe_if.sv - weight-load, activation and partial-sum bundle of the sparse PE
interface vegeta_sparse_pe_if
    import vegeta_pkg::*;
#(
    parameter int ALPHA          = 4,
    parameter int BETA           = 4,
    parameter int MUL_DATAWIDTH  = 8,
    parameter int ADD_DATAWIDTH  = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int META_DATA_SIZE = clog2_min1(BLOCK_SIZE)
);

    logic                                         w_valid;
    logic                                         w_ready;
    logic [BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] w_data;
    logic                                         w_swap;
    logic                                         w_bank;
    logic                                         shadow_full;
    logic                                         act_valid;
    logic [MUL_DATAWIDTH*BLOCK_SIZE*BETA-1:0]     act_in;
    logic [ALPHA*BETA*ADD_DATAWIDTH-1:0]          acc_in;
    logic                                         act_valid_out;
    logic [MUL_DATAWIDTH*BLOCK_SIZE*BETA-1:0]     act_out;
    logic                                         acc_valid;
    logic [ALPHA*BETA*ADD_DATAWIDTH-1:0]          acc_out;

    modport master (
        output w_valid, w_data, w_swap, act_valid, act_in, acc_in,
        input  w_ready, w_bank, shadow_full, act_valid_out, act_out, acc_valid, acc_out
    );

    modport slave (
        input  w_valid, w_data, w_swap, act_valid, act_in, acc_in,
        output w_ready, w_bank, shadow_full, act_valid_out, act_out, acc_valid, acc_out
    );

endinterface

// File: rtl/vegeta_sparse_lane.sv
// rtl/vegeta_sparse_lane.sv - one sparse MAC lane: metadata operand select, multiply, 2-stage accumulate
// Define VEGETA_PE_SAT_EN to saturate the accumulate instead of wrapping.
module vegeta_sparse_lane #(
    parameter int MUL_DATAWIDTH  = 8,
    parameter int ADD_DATAWIDTH  = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int META_DATA_SIZE = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  act_valid,
    input  logic [MUL_DATAWIDTH*BLOCK_SIZE-1:0]   act_block,
    input  logic [META_DATA_SIZE-1:0]             meta,
    input  logic signed [MUL_DATAWIDTH-1:0]       value,
    input  logic signed [ADD_DATAWIDTH-1:0]       acc_in,
    output logic                                  acc_valid,
    output logic signed [ADD_DATAWIDTH-1:0]       acc_out
);

    localparam int PROD_W = 2 * MUL_DATAWIDTH;

    logic signed [MUL_DATAWIDTH-1:0] operand;
    logic signed [PROD_W-1:0]        prod_d;
    logic                            s1_valid;
    logic signed [PROD_W-1:0]        s1_prod;
    logic signed [ADD_DATAWIDTH-1:0] s1_acc;
    logic signed [ADD_DATAWIDTH-1:0] prod_ext;
    logic signed [ADD_DATAWIDTH-1:0] sum_d;

    // Metadata outside the block (non power-of-two BLOCK_SIZE) falls through to element 0.
    always_comb begin
        operand = act_block[0 +: MUL_DATAWIDTH];
        for (int k = 1; k < BLOCK_SIZE; k++) begin
            if (meta == META_DATA_SIZE'(k)) begin
                operand = act_block[k*MUL_DATAWIDTH +: MUL_DATAWIDTH];
            end
        end
    end

    assign prod_d   = value * operand;
    assign prod_ext = {{(ADD_DATAWIDTH-PROD_W){s1_prod[PROD_W-1]}}, s1_prod};

`ifdef VEGETA_PE_SAT_EN
    logic signed [ADD_DATAWIDTH:0] sum_wide;

    always_comb begin
        sum_wide = {s1_acc[ADD_DATAWIDTH-1], s1_acc} + {prod_ext[ADD_DATAWIDTH-1], prod_ext};
        sum_d    = sum_wide[ADD_DATAWIDTH-1:0];
        if (sum_wide[ADD_DATAWIDTH] != sum_wide[ADD_DATAWIDTH-1]) begin
            sum_d = sum_wide[ADD_DATAWIDTH] ? {1'b1, {(ADD_DATAWIDTH-1){1'b0}}}
                                            : {1'b0, {(ADD_DATAWIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_d = s1_acc + prod_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_acc    <= '0;
            acc_valid <= 1'b0;
            acc_out   <= '0;
        end else begin
            s1_valid  <= act_valid;
            if (act_valid) begin
                s1_prod <= prod_d;
                s1_acc  <= acc_in;
            end
            acc_valid <= s1_valid;
            if (s1_valid) begin
                acc_out <= sum_d;
            end
        end
    end

endmodule

// File: rtl/vegeta_sparse_pe.sv
// rtl/vegeta_sparse_pe.sv - N:M sparse PE with double-buffered weights and ALPHA x BETA MAC lanes
// Define VEGETA_PE_SAT_EN for saturating accumulation (default wraps).
module vegeta_sparse_pe
    import vegeta_pkg::*;
#(
    parameter int ALPHA          = 4,
    parameter int BETA           = 4,
    parameter int MUL_DATAWIDTH  = 8,
    parameter int ADD_DATAWIDTH  = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int META_DATA_SIZE = clog2_min1(BLOCK_SIZE)
) (
    input logic                clk,
    input logic                rst_n,
    vegeta_sparse_pe_if.slave  pe
);

    localparam int ENTRY_W = MUL_DATAWIDTH + META_DATA_SIZE;
    localparam int ROW_W   = clog2_min1(ALPHA);
    localparam int BLK_W   = MUL_DATAWIDTH * BLOCK_SIZE;
    localparam int ACT_W   = BLK_W * BETA;

    ld_state_e              state_q, state_d;
    logic [ROW_W-1:0]       row_cnt_q, row_cnt_d;
    logic                   bank_q, bank_d;
    logic                   w_ready_c;
    logic                   beat;
    w_entry_t               w_row [BETA];
    w_entry_t               wbank [2][ALPHA][BETA];
    logic                   act_valid_q;
    logic [ACT_W-1:0]       act_q;
    logic [ALPHA*BETA-1:0]  lane_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            row_cnt_q <= '0;
            bank_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            bank_q    <= bank_d;
        end
    end

    // The last row (row_cnt == ALPHA-1) completes the set; ALPHA==1 therefore goes EMPTY->FULL.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        bank_d    = bank_q;
        w_ready_c = 1'b0;
        case (state_q)
            EMPTY, LOADING: begin
                w_ready_c = 1'b1;
                if (pe.w_valid) begin
                    if (row_cnt_q == ROW_W'(ALPHA-1)) begin
                        state_d   = FULL;
                        row_cnt_d = '0;
                    end else begin
                        state_d   = LOADING;
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (pe.w_swap) begin
                    bank_d  = ~bank_q;
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign beat           = pe.w_valid & w_ready_c;
    assign pe.w_ready     = w_ready_c;
    assign pe.w_bank      = bank_q;
    assign pe.shadow_full = (state_q == FULL);

    always_comb begin
        for (int j = 0; j < BETA; j++) begin
            w_row[j].meta  = META_MAX_W'(pe.w_data[j*ENTRY_W+MUL_DATAWIDTH +: META_DATA_SIZE]);
            w_row[j].value = MUL_MAX_W'(pe.w_data[j*ENTRY_W +: MUL_DATAWIDTH]);
        end
    end

    // Loads always target the bank that is not currently feeding the lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < ALPHA; i++) begin
                    for (int j = 0; j < BETA; j++) begin
                        wbank[b][i][j] <= '0;
                    end
                end
            end
        end else if (beat) begin
            for (int j = 0; j < BETA; j++) begin
                wbank[~bank_q][row_cnt_q][j] <= w_row[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_valid_q <= 1'b0;
            act_q       <= '0;
        end else begin
            act_valid_q <= pe.act_valid;
            if (pe.act_valid) begin
                act_q <= pe.act_in;
            end
        end
    end

    assign pe.act_valid_out = act_valid_q;
    assign pe.act_out       = act_q;

    // Lanes read bank_q combinationally, so an activation coinciding with a swap uses the old bank.
    for (genvar i = 0; i < ALPHA; i++) begin : g_row
        for (genvar j = 0; j < BETA; j++) begin : g_lane
            vegeta_sparse_lane #(
                .MUL_DATAWIDTH  (MUL_DATAWIDTH),
                .ADD_DATAWIDTH  (ADD_DATAWIDTH),
                .BLOCK_SIZE     (BLOCK_SIZE),
                .META_DATA_SIZE (META_DATA_SIZE)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .act_valid (pe.act_valid),
                .act_block (pe.act_in[j*BLK_W +: BLK_W]),
                .meta      (wbank[bank_q][i][j].meta[META_DATA_SIZE-1:0]),
                .value     (wbank[bank_q][i][j].value[MUL_DATAWIDTH-1:0]),
                .acc_in    (pe.acc_in[(i*BETA+j)*ADD_DATAWIDTH +: ADD_DATAWIDTH]),
                .acc_valid (lane_valid[i*BETA+j]),
                .acc_out   (pe.acc_out[(i*BETA+j)*ADD_DATAWIDTH +: ADD_DATAWIDTH])
            );
        end
    end

    // All lanes share one valid pipeline; the reduction just collapses identical bits.
    assign pe.acc_valid = &lane_valid;

endmodule

// File: doc/vegeta_sparse_pe.md
VEGETA_SPARSE_PE -- requirements
Module: vegeta_sparse_pe

Interface
REQ-001 Parameter ALPHA, default 4, number of PU rows.
REQ-002 Parameter BETA, default 4, number of lanes (column blocks) per PU row.
REQ-003 Parameter MUL_DATAWIDTH, default 8, signed operand width.
REQ-004 Parameter ADD_DATAWIDTH, default 32, signed accumulator width; SHALL be >= 2*MUL_DATAWIDTH.
REQ-005 Parameter BLOCK_SIZE, default 4, activation elements per sparse block (M of N:M).
REQ-006 Parameter META_DATA_SIZE, default clog2(BLOCK_SIZE) with a minimum of 1, index width per weight.
REQ-007 clk  in  1  clock; all state on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 w_valid  in  1  weight beat valid.
REQ-010 w_ready  out  1  shadow bank accepts a beat.
REQ-011 w_data  in  BETA*(MUL_DATAWIDTH+META_DATA_SIZE)  one PU row; lane j = {meta, value} at slice j.
REQ-012 w_swap  in  1  request to make the shadow bank active.
REQ-013 w_bank  out  1  index of the active bank.
REQ-014 shadow_full  out  1  shadow bank holds a complete set of ALPHA rows.
REQ-015 act_valid  in  1  act_in and acc_in valid.
REQ-016 act_in  in  MUL_DATAWIDTH*BLOCK_SIZE*BETA  BETA blocks of BLOCK_SIZE elements.
REQ-017 acc_in  in  ALPHA*BETA*ADD_DATAWIDTH  partial sums; PU i, lane j at slice i*BETA+j.
REQ-018 act_valid_out / act_out  out  1 / as act_in  registered forward to the right neighbour.
REQ-019 acc_valid / acc_out  out  1 / as acc_in  result partial sums.

Function
REQ-020 Two weight banks of ALPHA rows each SHALL exist: one active (feeding compute), one shadow (loading).
REQ-021 Loader FSM SHALL have states EMPTY, LOADING, FULL; w_ready=1 in EMPTY and LOADING, 0 in FULL.
REQ-022 A beat (w_valid & w_ready) SHALL write shadow row row_cnt, then increment row_cnt; the first beat moves EMPTY->LOADING.
REQ-023 The beat at row_cnt==ALPHA-1 SHALL move to FULL (shadow_full=1) and clear row_cnt; ALPHA==1 moves EMPTY->FULL directly.
REQ-024 w_swap in FULL SHALL toggle w_bank at that edge and return the FSM to EMPTY; w_swap in EMPTY/LOADING SHALL be ignored.
REQ-025 An act_valid in the same cycle as an accepted swap SHALL use the pre-swap (old) active bank.
REQ-026 Lane (i,j) operand SHALL be act_in element j*BLOCK_SIZE+meta[i][j] of the active bank; a meta value >= BLOCK_SIZE SHALL select element 0.
REQ-027 Stage 1 (edge after act_valid): signed product value*operand and acc_in SHALL be registered with a valid bit.
REQ-028 Stage 2: acc_out = acc_in + sign-extended product, wrapping modulo 2^ADD_DATAWIDTH; acc_valid asserted.
REQ-029 Latency act_valid->acc_valid SHALL be exactly 2 cycles, with throughput of 1 per cycle and no stall.
REQ-030 act_out/act_valid_out SHALL be act_in/act_valid delayed by 1 cycle; act_out holds its value when act_valid=0.
REQ-031 acc_out SHALL hold its last value while acc_valid=0.

Reset
REQ-032 Reset SHALL clear both banks, the pipeline, act_out, acc_out, and all valids, and set row_cnt=0, FSM=EMPTY, w_bank=0, shadow_full=0.
REQ-033 w_ready SHALL be 1 from the first cycle after reset release.
REQ-034 Reset mid-load SHALL discard the partial shadow contents; reset mid-pipeline SHALL drop in-flight results.

Configuration
REQ-035 Macro VEGETA_PE_SAT_EN defined: the stage-2 sum SHALL saturate to the signed ADD_DATAWIDTH range.
REQ-036 Macro VEGETA_PE_SAT_EN undefined: the sum SHALL wrap as in REQ-028.

Structure
REQ-037 Package vegeta_pkg SHALL hold the loader-state enum, the weight-entry struct {meta, value}, and the clog2-with-minimum-1 function.
REQ-038 Sub-module vegeta_sparse_lane SHALL implement one lane: operand mux, multiply, two pipeline stages, add/saturate; it is instanced ALPHA*BETA times.

Verification
REQ-039 Load 4 rows with w_valid held high: w_ready drops after the 4th beat, shadow_full=1; w_swap -> w_bank=1, w_ready=1 the next cycle.
REQ-040 Lane (0,0) with value=3 and meta=2, act block0={5,6,7,8}, acc_in=10: acc_out[0]=31 exactly 2 cycles later.
REQ-041 Back-to-back act_valid for 8 cycles: acc_valid high for 8 consecutive cycles starting 2 cycles after the first; act_out is a 1-cycle copy.
REQ-042 w_swap asserted during LOADING after 2 beats: w_bank is unchanged and the FSM continues to FULL after 2 more beats.
REQ-043 value=-128, operand=-128, acc_in=0x7FFFFFFF: with SAT_EN, acc_out=0x7FFFFFFF; without it, acc_out=0x80003FFF.
REQ-044 rst_n low after 2 of 4 beats: shadow_full=0, w_bank=0, acc_valid=0; a full reload then behaves as in REQ-039.
